// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero on underflow (saturating subtract).
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CNT_W-1:0] cnt;

   // Full-subtractor bit cell built from two half-subtractor stages
   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] diff_shifted;

   assign d            = a_sh[0] ^ b_sh[0] ^ br;
   assign br_next      = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign diff_shifted = {d, diff[WIDTH-1:1]};

   assign in_ready  = (state == IDLE);
   assign busy      = (state == SHIFT);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  diff  <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_next;
               cnt  <= cnt + CNT_W'(1);
               diff <= diff_shifted;
               if (cnt == LAST_BIT) begin
                  state  <= DONE;
                  borrow <= br_next;
`ifdef SERIAL_SUB_SAT_EN
                  // Clamp registered together with the final bit so diff is stable in DONE
                  if (br_next) begin
                     diff <= '0;
                  end
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_SAT_EN.
module tb_serial_subtractor;

   localparam int WIDTH = 8;
`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;

   int tests_run;
   int tests_failed;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      tests_run++;
      if (got !== expv) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   // Present operands for one cycle; returns just after the accepting edge
   task automatic start_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bin);
      @(negedge clk);
      check("accept_ready", 32'(in_ready), 32'd1);
      a        = op_a;
      b        = op_b;
      bin      = op_bin;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Walk the WIDTH shift cycles, optionally pulsing in_valid at one of them, then check the result
   task automatic wait_result(input string tag, input logic [7:0] exp_diff_raw, input logic exp_borrow,
                              input int pulse_at);
      logic [7:0] exp_diff;
      exp_diff = (SAT && exp_borrow) ? 8'h00 : exp_diff_raw;
      for (int i = 1; i <= WIDTH; i++) begin
         @(negedge clk);
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
         if (i == 1) check({tag, "_diff_cleared"}, 32'(diff), 32'd0);
         if (i == pulse_at) begin
            a = 8'h01; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
      check({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
      $display("[TB] %s: diff=0x%02h borrow=%0b (expected 0x%02h/%0b)", tag, diff, borrow, exp_diff, exp_borrow);
   endtask

   // out_ready assumed high: result retires on the next edge
   task automatic retire(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bin,
                         input logic [7:0] exp_diff, input logic exp_borrow);
      start_op(op_a, op_b, op_bin);
      wait_result(tag, exp_diff, exp_borrow, 0);
      retire(tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] held_diff;
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);

      run_op("t1_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
      run_op("t2_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
      run_op("t3_00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
      run_op("t3_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      run_op("t_c8_37", 8'hC8, 8'h37, 1'b1, 8'h90, 1'b0);

      // Backpressure: hold the result for 5 cycles while in_valid is also asserted
      out_ready = 1'b0;
      start_op(8'h33, 8'h11, 1'b0);
      wait_result("t4_backpressure", 8'h22, 1'b0, 0);
      held_diff = diff;
      a = 8'hAA; b = 8'h55; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_in_ready", 32'(in_ready), 32'd0);
         check("t4_hold_diff", 32'(diff), 32'(held_diff));
         check("t4_hold_borrow", 32'(borrow), 32'd0);
      end
      in_valid = 1'b0;
      retire("t4_backpressure");
      @(negedge clk);
      check("t4_no_queue_busy", 32'(busy), 32'd0);

      // Busy overlap: a second operand pulse during SHIFT must be ignored
      start_op(8'h80, 8'h01, 1'b0);
      wait_result("t5_overlap", 8'h7F, 1'b0, 3);
      retire("t5_overlap");
      @(negedge clk);
      check("t5_no_second_op", 32'(busy), 32'd0);
      check("t5_diff_kept", 32'(diff), 32'h7F);

      // Leave borrow=1 registered so the mid-op reset has something to clear
      run_op("t6_pre", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_rst_in_ready", 32'(in_ready), 32'd1);
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_diff", 32'(diff), 32'd0);
      check("t6_rst_borrow", 32'(borrow), 32'd0);
      $display("[TB] t6_reset: mid-op reset, busy=%0b in_ready=%0b", busy, in_ready);
      run_op("t6_09_04", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
